// File: rtl/micro_pkg.sv
// micro_pkg: microword field layout, sequencer op codes and FSM states.
package micro_pkg;
    localparam int SEQ_OP_LSB   = 44;
    localparam int SEQ_OP_W     = 4;
    localparam int COND_SEL_LSB = 40;
    localparam int COND_SEL_W   = 4;
    localparam int TARGET_LSB   = 32;
    localparam int TARGET_W     = 8;
    localparam int CTRL_LSB     = 0;
    localparam int CTRL_W       = 32;

    typedef enum logic [3:0] {
        OP_NEXT     = 4'd0,
        OP_JUMP     = 4'd1,
        OP_JT       = 4'd2,
        OP_JF       = 4'd3,
        OP_CALL     = 4'd4,
        OP_RET      = 4'd5,
        OP_DISPATCH = 4'd6,
        OP_HALT     = 4'd7
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;
endpackage

// File: rtl/micro_stack.sv
// micro_stack: LIFO of 8-bit return addresses; top is valid whenever not empty.
module micro_stack #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] data,
    output logic [7:0] top,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] cnt;
    logic [AW-1:0] tix;

    assign tix   = AW'(cnt - 1'b1);
    assign top   = mem[tix];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (push && !full) cnt <= cnt + 1'b1;
        else if (pop && !empty) cnt <= cnt - 1'b1;

    always_ff @(posedge clk)
        if (push && !full) mem[cnt[AW-1:0]] <= data;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC, return stack, opcode dispatch and halt/fault
// control around a combinational microcode ROM.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter logic [7:0] RESET_VEC   = 8'h00,
    parameter int         ROM_DEPTH   = 192,
    parameter int         STACK_DEPTH = 4,
    parameter int         OPC_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [7:0]       rom_addr,
    input  logic [47:0]      rom_data,
    input  logic [15:0]      cond,
    input  logic             stall,
    input  logic [OPC_W-1:0] opcode,
    input  logic             opcode_valid,
    output logic             opcode_ready,
    input  logic             start,
    output logic [31:0]      ctrl,
    output logic             ctrl_valid,
    output logic             halted,
    output logic             fault
);
    state_e     state, state_nx;
    logic [7:0] upc, upc_nx, inc, target, top;
    logic [3:0] op, sel;
    logic       push, pop, full, empty, live;

    assign op       = rom_data[SEQ_OP_LSB +: SEQ_OP_W];
    assign sel      = rom_data[COND_SEL_LSB +: COND_SEL_W];
    assign target   = rom_data[TARGET_LSB +: TARGET_W];
    assign ctrl     = rom_data[CTRL_LSB +: CTRL_W];
    assign rom_addr = upc;
    assign inc      = upc + 8'd1;
    assign halted   = state == ST_HALT;
    assign fault    = state == ST_FAULT;
    // outputs stay quiet while reset is held, not just after the first edge
    assign live     = reset_n && !stall;

    always_comb begin
        state_nx     = state;
        upc_nx       = upc;
        push         = 1'b0;
        pop          = 1'b0;
        ctrl_valid   = 1'b0;
        opcode_ready = 1'b0;
        if (live && state == ST_HALT) begin
            if (start) begin
                upc_nx   = RESET_VEC;
                state_nx = ST_RUN;
            end
        end else if (live && state == ST_RUN) begin
            if ({1'b0, upc} >= 9'(ROM_DEPTH)) state_nx = ST_FAULT;
            else begin
                case (op)
                    OP_NEXT: begin
                        upc_nx     = inc;
                        ctrl_valid = 1'b1;
                    end
                    OP_JUMP: begin
                        upc_nx     = target;
                        ctrl_valid = 1'b1;
                    end
                    OP_JT: begin
                        upc_nx     = cond[sel] ? target : inc;
                        ctrl_valid = 1'b1;
                    end
                    OP_JF: begin
                        upc_nx     = !cond[sel] ? target : inc;
                        ctrl_valid = 1'b1;
                    end
                    OP_CALL: begin
                        if (full) state_nx = ST_FAULT;
                        else begin
                            push       = 1'b1;
                            upc_nx     = target;
                            ctrl_valid = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (empty) state_nx = ST_FAULT;
                        else begin
                            pop        = 1'b1;
                            upc_nx     = top;
                            ctrl_valid = 1'b1;
                        end
                    end
                    OP_DISPATCH: begin
                        opcode_ready = opcode_valid;
                        if (opcode_valid) begin
                            upc_nx     = target + 8'(opcode);
                            ctrl_valid = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        state_nx   = ST_HALT;
                        ctrl_valid = 1'b1;
                    end
                    default: state_nx = ST_FAULT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= ST_RUN;
            upc   <= RESET_VEC;
        end else begin
            state <= state_nx;
            upc   <= upc_nx;
        end

    micro_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .pop(pop),
        .data(inc),
        .top(top),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed scenarios plus random microcode, checked against
// a queue-based behavioural model of the sequencing rules.
module tb_micro_sequencer;
    localparam logic [7:0] RV = 8'h00;

    logic        clk = 0, reset_n = 0, stall = 0, opcode_valid = 0, start = 0;
    logic [3:0]  opcode = 0;
    logic [15:0] cond = 0;
    logic [47:0] rom_data;
    logic [7:0]  rom_addr;
    logic        opcode_ready, ctrl_valid, halted, fault;
    logic [31:0] ctrl;
    logic [47:0] rom [256];
    int          total = 0, bad = 0;
    int          m_upc, m_state;
    int          m_stk [$];
    logic [43:0] exp;
    wire  [43:0] got = {rom_addr, ctrl_valid, opcode_ready, halted, fault, ctrl};

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    micro_sequencer #(.RESET_VEC(RV), .ROM_DEPTH(192), .STACK_DEPTH(4), .OPC_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .cond(cond), .stall(stall), .opcode(opcode), .opcode_valid(opcode_valid),
        .opcode_ready(opcode_ready), .start(start), .ctrl(ctrl),
        .ctrl_valid(ctrl_valid), .halted(halted), .fault(fault)
    );

    function automatic logic [47:0] mw(input logic [3:0] op, input logic [3:0] sel, input logic [7:0] tg);
        return {op, sel, tg, 32'($urandom)};
    endfunction

    // model state: 0 run, 1 halt, 2 fault
    task automatic model(input bit s, input bit ov, input logic [3:0] opc, input bit sr, input logic [15:0] c);
        logic [47:0] w;
        int op, sel, tg, a0;
        bit cv, rdy, h0, f0;
        w = rom[m_upc]; op = int'(w[47:44]); sel = int'(w[43:40]); tg = int'(w[39:32]);
        a0 = m_upc; h0 = m_state == 1; f0 = m_state == 2; cv = 0; rdy = 0;
        if (!s && m_state == 1) begin
            if (sr) begin m_upc = int'(RV); m_state = 0; end
        end else if (!s && m_state == 0) begin
            if (m_upc >= 192) m_state = 2;
            else case (op)
                0: begin cv = 1; m_upc = (m_upc + 1) % 256; end
                1: begin cv = 1; m_upc = tg; end
                2: begin cv = 1; m_upc = c[sel] ? tg : (m_upc + 1) % 256; end
                3: begin cv = 1; m_upc = !c[sel] ? tg : (m_upc + 1) % 256; end
                4: if (m_stk.size() == 4) m_state = 2;
                   else begin cv = 1; m_stk.push_back((m_upc + 1) % 256); m_upc = tg; end
                5: if (m_stk.size() == 0) m_state = 2;
                   else begin cv = 1; m_upc = m_stk.pop_back(); end
                6: begin rdy = ov; if (ov) begin cv = 1; m_upc = (tg + int'(opc)) % 256; end end
                7: begin cv = 1; m_state = 1; end
                default: m_state = 2;
            endcase
        end
        exp = {8'(a0), cv, rdy, h0, f0, w[31:0]};
    endtask

    task automatic cyc(input bit s, input bit ov, input logic [3:0] opc, input bit sr, input logic [15:0] c);
        @(negedge clk);
        stall = s; opcode_valid = ov; opcode = opc; start = sr; cond = c;
        #1 model(s, ov, opc, sr, c);
    endtask

    task automatic rnd();
        cyc(1'b0, 1'($urandom), 4'($urandom), 1'b0, 16'($urandom));
    endtask

    task automatic fill_next();
        for (int i = 0; i < 256; i++) rom[i] = mw(4'd0, 4'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; stall = 0; opcode_valid = 0; start = 0;
        m_upc = int'(RV); m_stk.delete(); m_state = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic test_reset();
        fill_next();
        reset_n = 0; m_upc = int'(RV); m_stk.delete(); m_state = 0;
        repeat (2) @(negedge clk);
        #1 total++;
        if ({rom_addr, ctrl_valid, opcode_ready, halted, fault} !== {RV, 4'b0000}) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", {rom_addr, ctrl_valid, opcode_ready, halted, fault}, {RV, 4'b0000});
        end
        @(posedge clk);
        #1 reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 16'($urandom));
            total++;
            if (got !== exp || rom_addr !== 8'(i) || ctrl_valid !== 1'b1) begin
                bad++; $display("FAIL reset_seq i=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 4; k++) begin
            bit jf = k[1];
            bit v = k[0];
            fill_next();
            rom[5] = mw(jf ? 4'd3 : 4'd2, 4'd3, 8'h40);
            do_reset();
            for (int i = 0; i < 7; i++) begin
                logic [15:0] c;
                c = 16'($urandom);
                if (i == 5) c[3] = v;
                cyc(1'b0, 1'($urandom), 4'($urandom), 1'b0, c);
                total++;
                if (got !== exp || (i == 6 && rom_addr !== ((v ^ jf) ? 8'h40 : 8'h06))) begin
                    bad++; $display("FAIL branch jf=%0d c3=%0d i=%0d got=%h exp=%h", jf, v, i, got, exp);
                end
            end
        end
    endtask

    task automatic test_call_ret();
        logic [7:0] seq [10] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h31, 8'h21, 8'h11, 8'h01, 8'h02};
        fill_next();
        rom[8'h00] = mw(4'd4, 4'd0, 8'h10); rom[8'h10] = mw(4'd4, 4'd0, 8'h20);
        rom[8'h20] = mw(4'd4, 4'd0, 8'h30); rom[8'h30] = mw(4'd4, 4'd0, 8'h40);
        rom[8'h40] = mw(4'd5, 4'd0, 8'h00); rom[8'h31] = mw(4'd5, 4'd0, 8'h00);
        rom[8'h21] = mw(4'd5, 4'd0, 8'h00); rom[8'h11] = mw(4'd5, 4'd0, 8'h00);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rnd();
            total++;
            if (got !== exp || rom_addr !== seq[i] || ctrl_valid !== 1'b1) begin
                bad++; $display("FAIL call_ret i=%0d got=%h exp=%h want_addr=%h", i, got, exp, seq[i]);
            end
        end
        rom[8'h40] = mw(4'd4, 4'd0, 8'h50);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rnd();
            total++;
            if (got !== exp || (i >= 4 && (ctrl_valid !== 1'b0 || rom_addr !== 8'h40)) ||
                (i >= 5 && (fault !== 1'b1 || halted !== 1'b0))) begin
                bad++; $display("FAIL call_overflow i=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_dispatch();
        for (int k = 0; k < 3; k++) begin
            logic [3:0] opr;
            opr = (k == 0) ? 4'h5 : 4'($urandom);
            fill_next();
            rom[8'h00] = mw(4'd1, 4'd0, 8'h10);
            rom[8'h10] = mw(4'd6, 4'd0, 8'h80);
            do_reset();
            rnd();
            total++;
            if (got !== exp || rom_addr !== 8'h00) begin bad++; $display("FAIL disp_entry got=%h exp=%h", got, exp); end
            for (int j = 0; j < 3; j++) begin
                cyc(j == 1, j == 1, 4'($urandom), 1'b0, 16'($urandom));
                total++;
                if (got !== exp || rom_addr !== 8'h10 || ctrl_valid !== 1'b0 || opcode_ready !== 1'b0) begin
                    bad++; $display("FAIL disp_wait j=%0d got=%h exp=%h", j, got, exp);
                end
            end
            cyc(1'b0, 1'b1, opr, 1'b0, 16'($urandom));
            total++;
            if (got !== exp || opcode_ready !== 1'b1 || ctrl_valid !== 1'b1) begin
                bad++; $display("FAIL disp_take got=%h exp=%h", got, exp);
            end
            cyc(1'b0, 1'b1, 4'($urandom), 1'b0, 16'($urandom));
            total++;
            if (got !== exp || rom_addr !== 8'h80 + 8'(opr) || opcode_ready !== 1'b0) begin
                bad++; $display("FAIL disp_target got=%h exp=%h opc=%h", got, exp, opr);
            end
        end
    endtask

    task automatic test_stall();
        int seen = 0;
        fill_next();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bit s = (i == 2 || i == 3);
            cyc(s, 1'($urandom), 4'($urandom), 1'b0, 16'($urandom));
            total++;
            if (got !== exp || ctrl_valid !== !s || rom_addr !== 8'(seen)) begin
                bad++; $display("FAIL stall i=%0d got=%h exp=%h want_addr=%0d", i, got, exp, seen);
            end
            seen += s ? 0 : 1;
        end
        rom[8'h00] = mw(4'd4, 4'd0, 8'h60);
        do_reset();
        rnd();
        rnd();
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 16'h0);
        #1 reset_n = 0;
        #1 total++;
        if ({rom_addr, ctrl_valid, opcode_ready, halted, fault} !== {RV, 4'b0000}) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", {rom_addr, ctrl_valid, opcode_ready, halted, fault}, {RV, 4'b0000});
        end
        m_upc = int'(RV); m_stk.delete(); m_state = 0;
        rom[8'h00] = mw(4'd5, 4'd0, 8'h00);
        @(posedge clk);
        #1 reset_n = 1;
        for (int i = 0; i < 2; i++) begin
            rnd();
            total++;
            if (got !== exp || ctrl_valid !== 1'b0 || fault !== (i == 1)) begin
                bad++; $display("FAIL stack_cleared i=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_halt_fault();
        bit hs [6] = '{0, 1, 0, 0, 1, 0};
        bit hh [6] = '{0, 0, 1, 1, 1, 0};
        bit hv [6] = '{1, 1, 0, 0, 0, 1};
        fill_next();
        rom[8'h00] = mw(4'd1, 4'd0, 8'h20);
        rom[8'h20] = mw(4'd7, 4'd0, 8'h00);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'($urandom), 4'($urandom), hs[i], 16'($urandom));
            total++;
            if (got !== exp || halted !== hh[i] || ctrl_valid !== hv[i] || (i == 5 && rom_addr !== RV)) begin
                bad++; $display("FAIL halt i=%0d got=%h exp=%h", i, got, exp);
            end
        end
        rom[8'h00] = mw(4'd1, 4'd0, 8'hBE);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'($urandom), 4'($urandom), 1'b1, 16'($urandom));
            total++;
            if (got !== exp || (i >= 3 && (rom_addr !== 8'd192 || ctrl_valid !== 1'b0)) || fault !== (i >= 4)) begin
                bad++; $display("FAIL rom_bound i=%0d got=%h exp=%h", i, got, exp);
            end
        end
        rom[8'h00] = mw(4'(8 + $urandom_range(0, 7)), 4'd0, 8'h00);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 4'h0, 1'b1, 16'($urandom));
            total++;
            if (got !== exp || ctrl_valid !== 1'b0 || fault !== (i >= 1) || halted !== 1'b0) begin
                bad++; $display("FAIL reserved i=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 256; a++) begin
                int p;
                logic [3:0] op;
                p = $urandom_range(0, 99);
                op = p < 30 ? 4'd0 : p < 40 ? 4'd1 : p < 50 ? 4'd2 : p < 60 ? 4'd3 :
                     p < 70 ? 4'd4 : p < 80 ? 4'd5 : p < 88 ? 4'd6 : p < 97 ? 4'd7 :
                     4'(8 + $urandom_range(0, 7));
                rom[a] = mw(op, 4'($urandom), 8'($urandom_range(0, 191)));
            end
            do_reset();
            for (int i = 0; i < 200; i++) begin
                if (m_state == 2 && $urandom_range(0, 4) == 0) do_reset();
                cyc($urandom_range(0, 4) == 0, 1'($urandom), 4'($urandom),
                    $urandom_range(0, 2) == 0, 16'($urandom));
                total++;
                if (got !== exp) begin
                    bad++; $display("FAIL random r=%0d i=%0d got=%h exp=%h", r, i, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_dispatch();
        test_stall();
        test_halt_fault();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
